// File: rtl/riscv_m_pkg.sv
// Shared types for the RV32M execute-stage units (divider and multiplier).
package riscv_m_pkg;

  localparam int XLEN = 32;

  // Divide unit operation select.
  typedef enum logic [2:0] {
    DIV_NONE = 3'd0,
    DIV      = 3'd1,
    DIVU     = 3'd2,
    REM      = 3'd3,
    REMU     = 3'd4
  } divsel_e;

  // Multiply unit operation select, kept alongside the divide codes.
  typedef enum logic [2:0] {
    MUL_NONE = 3'd0,
    MUL      = 3'd1,
    MULH     = 3'd2,
    MULHSU   = 3'd3,
    MULHU    = 3'd4
  } mulsel_e;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // True for the four real divide/remainder operations.
  function automatic logic divsel_valid(input logic [2:0] sel);
    return (sel == DIV) || (sel == DIVU) || (sel == REM) || (sel == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left by one, subtract the
// divisor when it fits and record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_next,
  output logic [WIDTH-1:0] o_quo_next
);

  // The shifted remainder carries one extra bit so the compare cannot wrap.
  logic [WIDTH:0] w_shifted;
  logic           w_fits;

  // Compare-and-subtract for a single quotient bit.
  always_comb begin
    w_shifted = {i_rem, i_quo[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, i_divisor});
    if (w_fits) begin
      // The difference is below the divisor, so it fits in WIDTH bits.
      o_rem_next = w_shifted[WIDTH-1:0] - i_divisor;
      o_quo_next = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem_next = w_shifted[WIDTH-1:0];
      o_quo_next = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module divider
  import riscv_m_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       divsel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] res
);

  localparam int               CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state;
  div_state_e       w_state_next;

  logic             r_is_signed;
  logic             r_want_rem;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_res;

  logic             w_accept;
  logic             w_signed;
  logic             w_rem_op;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_early;
  logic [WIDTH-1:0] w_early_res;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Decode the request and precompute magnitudes and early-exit results.
  always_comb begin
    w_accept    = (r_state == IDLE) && start && divsel_valid(divsel);
    w_signed    = (divsel == DIV) || (divsel == REM);
    w_rem_op    = (divsel == REM) || (divsel == REMU);
    w_abs_a     = (w_signed && a[WIDTH-1]) ? ('0 - a) : a;
    w_abs_b     = (w_signed && b[WIDTH-1]) ? ('0 - b) : b;
    w_div_zero  = (b == '0);
    w_overflow  = w_signed && (a == MIN_NEG) && (b == '1);
    w_early     = w_div_zero || w_overflow;
    if (w_div_zero) begin
      w_early_res = w_rem_op ? a : '1;
    end else begin
      w_early_res = w_rem_op ? '0 : MIN_NEG;
    end
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem      (r_rem),
    .i_quo      (r_quo),
    .i_divisor  (r_divisor),
    .o_rem_next (w_rem_step),
    .o_quo_next (w_quo_step)
  );

  // Restore RISC-V signs: quotient negative on sign mismatch, remainder follows dividend.
  always_comb begin
    w_quo_fix = (r_is_signed && (r_sign_a != r_sign_b)) ? ('0 - r_quo) : r_quo;
    w_rem_fix = (r_is_signed && r_sign_a) ? ('0 - r_rem) : r_rem;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    ready        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_early ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == LAST) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        busy         = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        ready        = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath, and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_signed <= 1'b0;
      r_want_rem  <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_res       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_signed <= w_signed;
            r_want_rem  <= w_rem_op;
            r_sign_a    <= a[WIDTH-1];
            r_sign_b    <= b[WIDTH-1];
            r_rem       <= '0;
            r_quo       <= w_abs_a;
            r_divisor   <= w_abs_b;
            r_count     <= '0;
            if (w_early) begin
              r_res <= w_early_res;
            end
          end
        end
        CALC: begin
          r_rem   <= w_rem_step;
          r_quo   <= w_quo_step;
          r_count <= r_count + 1'b1;
        end
        FIX: begin
          r_res <= r_want_rem ? w_rem_fix : w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign res = r_res;

endmodule
